// File: rtl/reg_file_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_scoreboard_pkg
//  Purpose  : Shared widths, constants and the source-busy helper for the
//             ID-stage register file and its pending-write scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_file_scoreboard_pkg;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int NUM_REGS     = 1 << ADDR_W;
    localparam int MAX_INFLIGHT = 3;
    localparam int CNT_W        = 2;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam addr_t REG_ZERO = 5'd0;

    // A sole writer retiring this very cycle is bypassed, so it does not count.
    function automatic logic src_busy(input addr_t src, input cnt_t cnt, input logic retiring);
        return (src != REG_ZERO) && (cnt != '0) && !((cnt == cnt_t'(1)) && retiring);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_scoreboard_if
//  Purpose  : ID read/issue and WB write-back signals of the register file.
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_file_scoreboard_if;
    import reg_file_scoreboard_pkg::*;

    addr_t src1;
    addr_t src2;
    data_t reg1;
    data_t reg2;
    logic  id_valid;
    logic  id_use_src2;
    logic  id_wb_en;
    addr_t id_dest;
    logic  stall;
    logic  wb_en;
    addr_t wb_dest;
    data_t wb_value;
    logic  err;

    modport master (
        output src1, src2, id_valid, id_use_src2, id_wb_en, id_dest,
        output wb_en, wb_dest, wb_value,
        input  reg1, reg2, stall, err
    );

    modport slave (
        input  src1, src2, id_valid, id_use_src2, id_wb_en, id_dest,
        input  wb_en, wb_dest, wb_value,
        output reg1, reg2, stall, err
    );

endinterface
`default_nettype wire

// File: rtl/reg_file_scoreboard_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_scoreboard_register_file
//  Purpose  : 32x32 storage, two asynchronous reads, one synchronous write,
//             R0 hardwired to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_scoreboard_register_file
    import reg_file_scoreboard_pkg::*;
(
    input  wire   clk,
    input  wire   rst,
    input  addr_t raddr1,
    input  addr_t raddr2,
    output data_t rdata1,
    output data_t rdata2,
    input  logic  we,
    input  addr_t waddr,
    input  data_t wdata
);

    data_t mem_q [NUM_REGS];
    data_t mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != REG_ZERO)) begin
            mem_d[waddr] = wdata;
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];

endmodule
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_scoreboard
//  Purpose  : Register file with per-register pending-writer counters, WB
//             write-through bypass and ID stall generation.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
(
    input  wire                  clk,
    input  wire                  rst,
    reg_file_scoreboard_if.slave bus
);

    data_t w_rf_rdata1;
    data_t w_rf_rdata2;
    logic  w_wb_hit;
    logic  w_busy1;
    logic  w_busy2;
    logic  w_full;
    logic  w_stall;
    logic  w_issue;

    cnt_t  cnt_q [NUM_REGS];
    cnt_t  cnt_d [NUM_REGS];
    logic  err_q;
    logic  err_d;

    reg_file_scoreboard_register_file u_rf (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (bus.src1),
        .raddr2 (bus.src2),
        .rdata1 (w_rf_rdata1),
        .rdata2 (w_rf_rdata2),
        .we     (bus.wb_en),
        .waddr  (bus.wb_dest),
        .wdata  (bus.wb_value)
    );

    assign w_wb_hit = bus.wb_en && (bus.wb_dest != REG_ZERO);

    assign bus.reg1 = (w_wb_hit && (bus.wb_dest == bus.src1)) ? bus.wb_value : w_rf_rdata1;
    assign bus.reg2 = (w_wb_hit && (bus.wb_dest == bus.src2)) ? bus.wb_value : w_rf_rdata2;

    always_comb begin
        w_busy1 = src_busy(bus.src1, cnt_q[bus.src1], w_wb_hit && (bus.wb_dest == bus.src1));
        w_busy2 = src_busy(bus.src2, cnt_q[bus.src2], w_wb_hit && (bus.wb_dest == bus.src2));
        // Destination already at the in-flight limit unless one of its writers retires now.
        w_full  = bus.id_wb_en && (bus.id_dest != REG_ZERO)
                  && (cnt_q[bus.id_dest] == cnt_t'(MAX_INFLIGHT))
                  && !(bus.wb_en && (bus.wb_dest == bus.id_dest));
        w_stall = bus.id_valid && (w_busy1 || (bus.id_use_src2 && w_busy2) || w_full);
        w_issue = bus.id_valid && !w_stall;
    end

    assign bus.stall = w_stall;

    always_comb begin
        logic w_inc;
        logic w_dec;
        err_d = err_q | (w_wb_hit && (cnt_q[bus.wb_dest] == '0));
        for (int i = 0; i < NUM_REGS; i++) begin
            w_inc = w_issue && bus.id_wb_en && (bus.id_dest != REG_ZERO)
                    && (bus.id_dest == addr_t'(i));
            w_dec = w_wb_hit && (bus.wb_dest == addr_t'(i)) && (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i] + cnt_t'(w_inc) - cnt_t'(w_dec);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_scoreboard
//  Purpose  : Directed and randomized checks of reg_file_scoreboard against a
//             count-of-pending-writers reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_scoreboard;
    import reg_file_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_file_scoreboard_if bus_if ();

    reg_file_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_cnt [NUM_REGS];
    logic [31:0] m_rf  [NUM_REGS];
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs from pending-writer counts, state committed at posedge.
    initial begin
        int          n_cnt [NUM_REGS];
        logic [31:0] n_rf  [NUM_REGS];
        bit          n_err;
        bit          wb_live, busy1, busy2, full, e_stall, issue;
        int          pend1, pend2, pendd;
        logic [31:0] e1, e2;
        for (int i = 0; i < NUM_REGS; i++) begin
            m_cnt[i] = 0;
            m_rf[i]  = '0;
        end
        m_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    m_cnt[i] = 0;
                    m_rf[i]  = '0;
                end
                m_err = 1'b0;
            end
            wb_live = bus_if.wb_en && (bus_if.wb_dest != 0);
            e1 = (wb_live && bus_if.wb_dest == bus_if.src1) ? bus_if.wb_value : m_rf[bus_if.src1];
            e2 = (wb_live && bus_if.wb_dest == bus_if.src2) ? bus_if.wb_value : m_rf[bus_if.src2];
            pend1 = m_cnt[bus_if.src1] - ((wb_live && bus_if.wb_dest == bus_if.src1) ? 1 : 0);
            pend2 = m_cnt[bus_if.src2] - ((wb_live && bus_if.wb_dest == bus_if.src2) ? 1 : 0);
            pendd = m_cnt[bus_if.id_dest] - ((wb_live && bus_if.wb_dest == bus_if.id_dest) ? 1 : 0);
            busy1 = (bus_if.src1 != 0) && (pend1 > 0);
            busy2 = (bus_if.src2 != 0) && (pend2 > 0);
            full  = bus_if.id_wb_en && (bus_if.id_dest != 0) && (pendd >= MAX_INFLIGHT);
            e_stall = bus_if.id_valid && (busy1 || (bus_if.id_use_src2 && busy2) || full);
            chk("reg1", bus_if.reg1, e1);
            chk("reg2", bus_if.reg2, e2);
            chk("stall", {31'b0, bus_if.stall}, {31'b0, e_stall});
            chk("err", {31'b0, bus_if.err}, {31'b0, m_err});

            n_cnt = m_cnt;
            n_rf  = m_rf;
            n_err = m_err;
            if (!rst) begin
                issue = bus_if.id_valid && !e_stall;
                if (wb_live) begin
                    n_rf[bus_if.wb_dest] = bus_if.wb_value;
                    if (n_cnt[bus_if.wb_dest] == 0) n_err = 1'b1;
                    else n_cnt[bus_if.wb_dest]--;
                end
                if (issue && bus_if.id_wb_en && bus_if.id_dest != 0) n_cnt[bus_if.id_dest]++;
            end
            @(posedge clk);
            m_cnt = n_cnt;
            m_rf  = n_rf;
            m_err = n_err;
        end
    end

    task automatic idle();
        bus_if.src1 = '0;  bus_if.src2 = '0;
        bus_if.id_valid = 1'b0; bus_if.id_use_src2 = 1'b0;
        bus_if.id_wb_en = 1'b0; bus_if.id_dest = '0;
        bus_if.wb_en = 1'b0; bus_if.wb_dest = '0; bus_if.wb_value = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_to(input int d);
        idle();
        bus_if.id_valid = 1'b1; bus_if.id_wb_en = 1'b1; bus_if.id_dest = addr_t'(d);
    endtask

    task automatic wb_to(input int d, input logic [31:0] v);
        bus_if.wb_en = 1'b1; bus_if.wb_dest = addr_t'(d); bus_if.wb_value = v;
    endtask

    initial begin
        int q [$];
        idle();
        #2;
        chk("rst_reg1", bus_if.reg1, 32'h0);
        chk("rst_stall", {31'b0, bus_if.stall}, 32'h0);
        chk("rst_err", {31'b0, bus_if.err}, 32'h0);
        nxt(); nxt();
        rst = 1'b0;

        // R0 is never written and never tracked
        wb_to(0, 32'hDEADBEEF);
        #5 chk("r0_bypass", bus_if.reg1, 32'h0);
        nxt();
        issue_to(0);
        #5 chk("r0_issue", {31'b0, bus_if.stall}, 32'h0);
        nxt();
        idle(); bus_if.id_valid = 1'b1;
        #5 chk("r0_read", bus_if.reg1, 32'h0);
        chk("r0_nostall", {31'b0, bus_if.stall}, 32'h0);
        nxt();

        // RAW on R7
        issue_to(7);
        #5 chk("raw_issue", {31'b0, bus_if.stall}, 32'h0);
        nxt();
        idle(); bus_if.id_valid = 1'b1; bus_if.src1 = 5'd7;
        #5 chk("raw_stall0", {31'b0, bus_if.stall}, 32'h1);
        nxt();
        #5 chk("raw_stall1", {31'b0, bus_if.stall}, 32'h1);
        nxt();
        wb_to(7, 32'h1234);
        #5 chk("raw_bypass_stall", {31'b0, bus_if.stall}, 32'h0);
        chk("raw_bypass_val", bus_if.reg1, 32'h1234);
        nxt();
        bus_if.wb_en = 1'b0;
        #5 chk("raw_rf_val", bus_if.reg1, 32'h1234);
        nxt();

        // WAW on R9 up to the in-flight limit
        repeat (3) begin
            issue_to(9);
            nxt();
        end
        issue_to(9);
        #5 chk("waw_full", {31'b0, bus_if.stall}, 32'h1);
        wb_to(9, 32'h1);
        #1 chk("waw_full_wb", {31'b0, bus_if.stall}, 32'h0);
        nxt();
        idle(); bus_if.id_valid = 1'b1; bus_if.src1 = 5'd9; wb_to(9, 32'h2);
        #5 chk("waw_wb1", {31'b0, bus_if.stall}, 32'h1);
        nxt();
        wb_to(9, 32'h3);
        #5 chk("waw_wb2", {31'b0, bus_if.stall}, 32'h1);
        nxt();
        wb_to(9, 32'h9999);
        #5 chk("waw_last_stall", {31'b0, bus_if.stall}, 32'h0);
        chk("waw_last_val", bus_if.reg1, 32'h9999);
        nxt();

        // Simultaneous issue and retire on R3
        issue_to(3);
        nxt();
        issue_to(3); wb_to(3, 32'h33);
        #5 chk("sim_stall", {31'b0, bus_if.stall}, 32'h0);
        nxt();
        idle(); bus_if.id_valid = 1'b1; bus_if.src1 = 5'd3;
        #5 chk("sim_busy", {31'b0, bus_if.stall}, 32'h1);
        nxt();
        idle(); wb_to(3, 32'h34);
        nxt();

        // Underflow on R4
        idle(); wb_to(4, 32'h55); bus_if.src1 = 5'd4;
        #5 chk("uf_err_pre", {31'b0, bus_if.err}, 32'h0);
        nxt();
        idle(); bus_if.src1 = 5'd4;
        #5 chk("uf_err", {31'b0, bus_if.err}, 32'h1);
        chk("uf_rf", bus_if.reg1, 32'h55);
        nxt(); nxt();
        #5 chk("uf_sticky", {31'b0, bus_if.err}, 32'h1);
        nxt();

        // Randomized traffic, writebacks only to registers with pending writers
        repeat (1500) begin
            idle();
            bus_if.src1 = addr_t'($urandom_range(0, 9));
            bus_if.src2 = addr_t'($urandom_range(0, 9));
            bus_if.id_valid = ($urandom_range(0, 3) != 0);
            bus_if.id_use_src2 = $urandom_range(0, 1) == 1;
            bus_if.id_wb_en = ($urandom_range(0, 3) != 0);
            bus_if.id_dest = addr_t'($urandom_range(0, 9));
            q.delete();
            for (int i = 1; i < NUM_REGS; i++) if (m_cnt[i] > 0) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 2) != 0)
                wb_to(q[$urandom_range(0, q.size() - 1)], $urandom);
            nxt();
        end

        // Drain, then reset with pending writers on R5
        for (int k = 0; k < 100; k++) begin
            idle();
            q.delete();
            for (int i = 1; i < NUM_REGS; i++) if (m_cnt[i] > 0) q.push_back(i);
            if (q.size() == 0) break;
            wb_to(q[0], $urandom);
            nxt();
        end
        idle(); wb_to(5, 32'hCAFE0005);
        nxt();
        issue_to(5);
        nxt();
        issue_to(5);
        nxt();
        idle(); bus_if.id_valid = 1'b1; bus_if.src1 = 5'd5;
        #5 chk("pre_rst_stall", {31'b0, bus_if.stall}, 32'h1);
        chk("pre_rst_val", bus_if.reg1, 32'hCAFE0005);
        nxt();
        rst = 1'b1;
        #1 chk("mid_rst_reg1", bus_if.reg1, 32'h0);
        chk("mid_rst_stall", {31'b0, bus_if.stall}, 32'h0);
        chk("mid_rst_err", {31'b0, bus_if.err}, 32'h0);
        nxt();
        rst = 1'b0;
        #5 chk("post_rst_stall", {31'b0, bus_if.stall}, 32'h0);
        nxt(); nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
